// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the word-addressed PC, fetches over a req/ack
// handshake, presents the instruction to decode over valid/ready and computes
// the next PC from sequential, branch (sign-extended offset) or jump targets.
// Optional build macro FETCH_STALL_COUNT_EN adds a saturating stall_cycles counter.
module fetch_unit #(
    parameter logic [29:0] RESET_PC = 30'h0010_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [29:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] imm16,
    input  logic [29:0] br_offset,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [25:0] jump_target,
`ifdef FETCH_STALL_COUNT_EN
    output logic [31:0] stall_cycles,
`endif
    output logic [29:0] pc
);

    typedef enum logic {StFetch, StHold} state_e;

    state_e      state_q;
    logic [29:0] pc_inc;
    logic [29:0] pc_next;

    assign imem_addr = pc;
    assign imm16     = instr[15:0];

    // Next PC for an accepted instruction; jump wins over a taken branch.
    always_comb begin
        pc_inc = pc + 30'd1;
        if (jump) begin
            pc_next = {pc_inc[29:26], jump_target};
        end else if (branch_taken) begin
            pc_next = pc_inc + br_offset;
        end else begin
            pc_next = pc_inc;
        end
    end

    // Fetch/hold FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StFetch;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state_q     <= StHold;
                    end
                end
                StHold: begin
                    // imem_ack is ignored here; instr and pc stay put until accepted.
                    if (instr_ready) begin
                        pc          <= pc_next;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state_q     <= StFetch;
                    end
                end
                default: begin
                    state_q <= StFetch;
                end
            endcase
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    // Count cycles spent waiting on instruction memory, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 32'h0;
        end else if (state_q == StFetch && !imem_ack && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked against a PC/instruction reference model.
module tb_fetch_unit;

    localparam logic [29:0] RESET_PC = 30'h0010_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] imm16;
    logic [29:0] br_offset;
    logic        branch_taken;
    logic        jump;
    logic [25:0] jump_target;
    logic [29:0] pc;
`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [29:0] ref_pc;
    logic [31:0] ref_instr;
    logic [31:0] ref_stall;
    logic        ref_valid;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .imm16        (imm16),
        .br_offset    (br_offset),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_target  (jump_target),
`ifdef FETCH_STALL_COUNT_EN
        .stall_cycles (stall_cycles),
`endif
        .pc           (pc)
    );

    always #5 clk = ~clk;

    // Reference next-PC rule: word PC + 1, then jump region splice or offset add, mod 2^30.
    function automatic logic [29:0] model_next(input logic [29:0] cur, input logic j,
                                               input logic b, input logic [29:0] off,
                                               input logic [25:0] tgt);
        logic [31:0] seq;
        seq = (32'(cur) + 32'd1) % 32'h4000_0000;
        if (j) return 30'((seq & 32'h3C00_0000) | 32'(tgt));
        if (b) return 30'((seq + 32'(off)) % 32'h4000_0000);
        return 30'(seq);
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        ref_pc    = RESET_PC;
        ref_valid = 1'b0;
        ref_stall = 32'h0;
    endtask

    // Fetch one word after `delay` ack-less cycles; checks the wait and the captured word.
    task automatic do_fetch(input int delay, input logic [31:0] data, input string tag);
        imem_ack = 1'b0;
        for (int i = 0; i < delay; i++) begin
            n_cmp++;
            if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, ref_pc}) begin
                n_fail++;
                $display("FAIL %s_wait: got valid=%0b req=%0b addr=%h, want valid=0 req=1 addr=%h",
                         tag, instr_valid, imem_req, imem_addr, ref_pc);
            end
            tick();
            if (ref_stall != 32'hFFFF_FFFF) ref_stall = ref_stall + 32'd1;
        end
        imem_rdata = data;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        ref_instr  = data;
        ref_valid  = 1'b1;
        n_cmp++;
        if ({instr_valid, imem_req, instr, imm16, pc} !==
            {1'b1, 1'b0, data, data[15:0], ref_pc}) begin
            n_fail++;
            $display("FAIL %s_capture: got valid=%0b req=%0b instr=%h imm16=%h pc=%h, want 1 0 %h %h %h",
                     tag, instr_valid, imem_req, instr, imm16, pc, data, data[15:0], ref_pc);
        end
    endtask

    // Accept the held instruction with the given control inputs; checks the new PC.
    task automatic do_accept(input logic j, input logic b, input logic [29:0] off,
                             input logic [25:0] tgt, input string tag);
        instr_ready  = 1'b1;
        jump         = j;
        branch_taken = b;
        br_offset    = off;
        jump_target  = tgt;
        tick();
        instr_ready  = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        ref_pc       = model_next(ref_pc, j, b, off, tgt);
        ref_valid    = 1'b0;
        n_cmp++;
        if ({instr_valid, imem_req, pc, imem_addr} !== {1'b0, 1'b1, ref_pc, ref_pc}) begin
            n_fail++;
            $display("FAIL %s_accept: got valid=%0b req=%0b pc=%h addr=%h, want 0 1 %h %h",
                     tag, instr_valid, imem_req, pc, imem_addr, ref_pc, ref_pc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({pc, instr, instr_valid, imem_req} !== {RESET_PC, 32'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h instr=%h valid=%0b req=%0b, want %h 0 0 1",
                     pc, instr, instr_valid, imem_req, RESET_PC);
        end
        tick();
        tick();
        reset     = 1'b0;
        ref_pc    = RESET_PC;
        ref_valid = 1'b0;
        ref_stall = 32'h0;
    endtask

    task automatic test_first_fetch;
        do_fetch(1, 32'h2008_0017, "first");
        n_cmp++;
        if ({imem_addr, imm16} !== {30'h0010_0000, 16'h0017}) begin
            n_fail++;
            $display("FAIL first_fields: got addr=%h imm16=%h, want 00100000 0017", imem_addr, imm16);
        end
        do_accept(1'b0, 1'b0, 30'h0, 26'h0, "first");
        n_cmp++;
        if (pc !== 30'h0010_0001) begin
            n_fail++;
            $display("FAIL first_seq_pc: got %h, want 00100001", pc);
        end
    endtask

    task automatic test_branch;
        for (int i = 0; i < 3; i++) begin
            do_fetch(0, $urandom, "seq");
            do_accept(1'b0, 1'b0, 30'($urandom), 26'($urandom), "seq");
        end
        do_fetch(2, $urandom, "branch");
        do_accept(1'b0, 1'b1, 30'h3FFF_FFE9, 26'($urandom), "branch");
        n_cmp++;
        if (pc !== 30'h000F_FFEE) begin
            n_fail++;
            $display("FAIL branch_pc: got %h, want 000fffee", pc);
        end
    endtask

    task automatic test_jump_priority;
        do_reset();
        do_fetch(0, $urandom, "jump");
        do_accept(1'b1, 1'b1, 30'($urandom), 26'h000_0040, "jump");
        n_cmp++;
        if (pc !== 30'h0000_0040) begin
            n_fail++;
            $display("FAIL jump_priority_pc: got %h, want 00000040", pc);
        end
    endtask

    task automatic test_wrap;
        do_fetch(0, $urandom, "wrap_a");
        do_accept(1'b0, 1'b1, 30'h3FFF_FFFF - 30'h41, 26'h0, "wrap_a");
        do_fetch(1, $urandom, "wrap_b");
        do_accept(1'b0, 1'b0, 30'h0, 26'h0, "wrap_b");
        n_cmp++;
        if (pc !== 30'h0) begin
            n_fail++;
            $display("FAIL wrap_seq_pc: got %h, want 00000000", pc);
        end
        do_fetch(0, $urandom, "wrap_c");
        do_accept(1'b0, 1'b1, 30'h3FFF_FFFE, 26'h0, "wrap_c");
        do_fetch(0, $urandom, "wrap_d");
        do_accept(1'b0, 1'b1, 30'd2, 26'h0, "wrap_d");
        // pc1 wraps to 0, plus offset 2
        n_cmp++;
        if (pc !== 30'h2) begin
            n_fail++;
            $display("FAIL wrap_branch_pc: got %h, want 00000002", pc);
        end
    endtask

    task automatic test_backpressure;
        do_fetch(int'($urandom_range(0, 2)), $urandom, "bp");
        for (int i = 0; i < 5; i++) begin
            instr_ready  = 1'b0;
            jump         = 1'($urandom);
            branch_taken = 1'($urandom);
            imem_ack     = (i == 2);
            imem_rdata   = $urandom;
            tick();
            n_cmp++;
            if ({instr, pc, instr_valid, imem_req} !== {ref_instr, ref_pc, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got instr=%h pc=%h valid=%0b req=%0b, want %h %h 1 0",
                         i, instr, pc, instr_valid, imem_req, ref_instr, ref_pc);
            end
        end
        imem_ack = 1'b0;
        do_accept(1'b0, 1'b0, 30'h0, 26'h0, "bp");
    endtask

    task automatic test_back_to_back;
        logic [29:0] start_pc;
        logic [31:0] data;
        start_pc     = ref_pc;
        imem_ack     = 1'b1;
        instr_ready  = 1'b1;
        jump         = 1'b0;
        branch_taken = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data       = $urandom;
            imem_rdata = data;
            tick();
            if (!ref_valid) begin
                ref_valid = 1'b1;
                ref_instr = data;
            end else begin
                ref_valid = 1'b0;
                ref_pc    = ref_pc + 30'd1;
            end
            n_cmp++;
            if ({instr_valid, pc} !== {ref_valid, ref_pc} || (ref_valid && instr !== ref_instr)) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got valid=%0b pc=%h instr=%h, want %0b %h %h",
                         i, instr_valid, pc, instr, ref_valid, ref_pc, ref_instr);
            end
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        n_cmp++;
        if (pc !== start_pc + 30'd5) begin
            n_fail++;
            $display("FAIL b2b_rate: got pc=%h, want %h", pc, start_pc + 30'd5);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 150; n++) begin
            do_fetch(int'($urandom_range(0, 3)), $urandom, "rnd");
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                imem_ack = 1'($urandom);
                tick();
                n_cmp++;
                if ({instr, pc, instr_valid} !== {ref_instr, ref_pc, 1'b1}) begin
                    n_fail++;
                    $display("FAIL rnd_hold: got instr=%h pc=%h valid=%0b, want %h %h 1",
                             instr, pc, instr_valid, ref_instr, ref_pc);
                end
            end
            imem_ack = 1'b0;
            do_accept(($urandom_range(0, 3) == 0), 1'($urandom), 30'($urandom),
                      26'($urandom), "rnd");
        end
`ifdef FETCH_STALL_COUNT_EN
        n_cmp++;
        if (stall_cycles !== ref_stall) begin
            n_fail++;
            $display("FAIL rnd_stall_count: got %0d, want %0d", stall_cycles, ref_stall);
        end
`endif
    endtask

    task automatic test_reset_mid;
        do_reset();
        do_fetch(0, $urandom, "rst");
        do_accept(1'b0, 1'b0, 30'h0, 26'h0, "rst");
        imem_ack = 1'b0;
        tick();
        tick();
        tick();
`ifdef FETCH_STALL_COUNT_EN
        n_cmp++;
        if (stall_cycles !== 32'd3) begin
            n_fail++;
            $display("FAIL rst_stall_before: got %0d, want 3", stall_cycles);
        end
`endif
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({pc, instr_valid, imem_req} !== {RESET_PC, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_fetch: got pc=%h valid=%0b req=%0b, want %h 0 1",
                     pc, instr_valid, imem_req, RESET_PC);
        end
`ifdef FETCH_STALL_COUNT_EN
        n_cmp++;
        if (stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_stall_after: got %0d, want 0", stall_cycles);
        end
`endif
        tick();
        reset     = 1'b0;
        ref_pc    = RESET_PC;
        ref_stall = 32'h0;
        do_fetch(1, $urandom, "rst_hold");
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({instr, instr_valid, imem_req, pc} !== {32'h0, 1'b0, 1'b1, RESET_PC}) begin
            n_fail++;
            $display("FAIL rst_mid_hold: got instr=%h valid=%0b req=%0b pc=%h, want 0 0 1 %h",
                     instr, instr_valid, imem_req, pc, RESET_PC);
        end
        tick();
        reset = 1'b0;
        do_fetch(0, 32'hDEAD_BEEF, "restart");
    endtask

    initial begin
        reset        = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        instr_ready  = 1'b0;
        br_offset    = 30'h0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jump_target  = 26'h0;
        ref_pc       = RESET_PC;
        ref_instr    = 32'h0;
        ref_stall    = 32'h0;
        ref_valid    = 1'b0;
        test_reset();
        test_first_fetch();
        test_branch();
        test_jump_priority();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
